// File: rtl/fifo_pkg.sv
// fifo_pkg: definitions shared by the handshake FIFO read and write sides.
//   rd_state_e      - read_unit FSM encoding (IDLE=0, STREAM=1, DRAIN=2, DONE=3)
//   TRAIL_OFFSET    - distance from the trailer-detect write address back to the
//                     frame stop address (applied by the write side)
//   DATA_WIDTH_DEF  - default FIFO word width
//   ADDR_WIDTH_DEF  - default FIFO address width
package fifo_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStream = 2'd1,
    StDrain  = 2'd2,
    StDone   = 2'd3
  } rd_state_e;

  localparam int unsigned TRAIL_OFFSET   = 24;
  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ADDR_WIDTH_DEF = 9;

endpackage

// File: rtl/rd_out_reg.sv
// rd_out_reg: registered valid/ready output stage of the FIFO read unit.
//   clk, rst    - read clock, asynchronous active-high reset
//   fetch       - a FIFO word is being read this cycle (loads rdata)
//   rdata       - FIFO word to capture
//   dout_ready  - consumer accepts dout_data when dout_valid is high
//   dout_data   - registered output word (changes only on fetch)
//   dout_valid  - dout_data holds a word not yet accepted
//   slot_free   - the register can take a new word this cycle
module rd_out_reg
  import fifo_pkg::*;
#(
  parameter int unsigned data_width = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch,
  input  logic [data_width-1:0] rdata,
  input  logic                  dout_ready,
  output logic [data_width-1:0] dout_data,
  output logic                  dout_valid,
  output logic                  slot_free
);

  logic [data_width-1:0] data_q;
  logic                  valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (fetch) begin
      data_q  <= rdata;
      valid_q <= 1'b1;
    end else if (dout_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Empty, or the current word leaves this cycle.
  assign slot_free  = !valid_q | dout_ready;
  assign dout_data  = data_q;
  assign dout_valid = valid_q;

endmodule

// File: rtl/read_unit.sv
// read_unit: drains handshake-FIFO entries into a registered valid/ready stream
// and stops at the frame stop address supplied by the write side, then pulses
// frame_done.
//   rclk, rrst  - read clock, asynchronous active-high reset
//   rdata       - FIFO word at raddr (combinational memory read)
//   rempty      - FIFO empty flag (read domain)
//   raddr       - current FIFO read address
//   trail_arm   - trailer-detected level, synchronized to rclk
//   stop_addr   - address at which reading stops, stable while trail_arm high
//   rinc        - read-pointer increment (combinational)
//   dout_data, dout_valid, dout_ready - output stream
//   frame_done  - one-cycle pulse once the frame is fully delivered
//   busy        - FSM is not idle
//   word_count  - accepted words this frame (only with READ_UNIT_WORD_COUNT_EN)
module read_unit
  import fifo_pkg::*;
#(
  parameter int unsigned data_width    = DATA_WIDTH_DEF,
  parameter int unsigned address_width = ADDR_WIDTH_DEF
) (
  input  logic                     rclk,
  input  logic                     rrst,
  input  logic [data_width-1:0]    rdata,
  input  logic                     rempty,
  input  logic [address_width-1:0] raddr,
  input  logic                     trail_arm,
  input  logic [address_width-1:0] stop_addr,
  output logic                     rinc,
  output logic [data_width-1:0]    dout_data,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     frame_done,
  output logic                     busy
`ifdef READ_UNIT_WORD_COUNT_EN
  ,
  output logic [address_width:0]   word_count
`endif
);

  rd_state_e                state_q, state_d;
  logic [address_width-1:0] stop_q, stop_d;
  logic                     arm_q;
  logic                     arm_rise;
  logic                     at_stop;
  logic                     slot_free;
  logic                     fetch;

  assign arm_rise = trail_arm & !arm_q;
  // Full-width equality keeps the compare correct across address wrap.
  assign at_stop  = (raddr == stop_q);

  assign fetch = !rrst
               & ((state_q == StStream) | (state_q == StDrain))
               & !rempty
               & slot_free
               & !((state_q == StDrain) & at_stop);

  assign rinc       = fetch;
  assign frame_done = (state_q == StDone);
  assign busy       = (state_q != StIdle);

  rd_out_reg #(
    .data_width (data_width)
  ) u_out_reg (
    .clk        (rclk),
    .rst        (rrst),
    .fetch      (fetch),
    .rdata      (rdata),
    .dout_ready (dout_ready),
    .dout_data  (dout_data),
    .dout_valid (dout_valid),
    .slot_free  (slot_free)
  );

  always_comb begin
    state_d = state_q;
    stop_d  = stop_q;
    unique case (state_q)
      StIdle: begin
        if (!rempty) state_d = StStream;
      end
      StStream: begin
        // A fetch issued in this same cycle still completes.
        if (arm_rise) begin
          stop_d  = stop_addr;
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Finish only once the last word has left the output register.
        if (at_stop && slot_free) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_q <= StIdle;
      stop_q  <= '0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stop_q  <= stop_d;
      // Sampled in every state so a level left high from an earlier frame
      // never looks like a fresh trailer on re-entry to STREAM.
      arm_q   <= trail_arm;
    end
  end

`ifdef READ_UNIT_WORD_COUNT_EN
  localparam logic [address_width:0] CntOne = 1;

  logic [address_width:0] word_count_q;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      word_count_q <= '0;
    end else if ((state_q == StIdle) && (state_d == StStream)) begin
      word_count_q <= '0;
    end else if (dout_valid && dout_ready) begin
      word_count_q <= word_count_q + CntOne;
    end
  end

  assign word_count = word_count_q;
`endif

endmodule

// File: tb/tb_read_unit.sv
module tb_read_unit;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 9;

  logic          rclk = 1'b0;
  logic          rrst;
  logic [DW-1:0] rdata;
  logic          rempty;
  logic [AW-1:0] raddr;
  logic [AW-1:0] wptr;
  logic          trail_arm;
  logic [AW-1:0] stop_addr;
  logic          rinc;
  logic [DW-1:0] dout_data;
  logic          dout_valid;
  logic          dout_ready;
  logic          frame_done;
  logic          busy;
`ifdef READ_UNIT_WORD_COUNT_EN
  logic [AW:0]   word_count;
`endif

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_q [$];

  int chk_cnt;
  int pass_cnt;
  int rinc_cnt;
  int done_cnt;
  logic prev_rinc;

  always #5 rclk = ~rclk;

  assign rdata  = mem[raddr];
  assign rempty = (raddr == wptr);

  read_unit #(
    .data_width    (DW),
    .address_width (AW)
  ) dut (
    .rclk       (rclk),
    .rrst       (rrst),
    .rdata      (rdata),
    .rempty     (rempty),
    .raddr      (raddr),
    .trail_arm  (trail_arm),
    .stop_addr  (stop_addr),
    .rinc       (rinc),
    .dout_data  (dout_data),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .frame_done (frame_done),
    .busy       (busy)
`ifdef READ_UNIT_WORD_COUNT_EN
    ,
    .word_count (word_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic load(input logic [DW-1:0] d, input bit expect_out);
    mem[wptr] = d;
    wptr = wptr + 9'd1;
    if (expect_out) exp_q.push_back(d);
  endtask

  task automatic wait_done(input int limit, output bit seen);
    int base;
    base = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge rclk);
      #1;
      if (done_cnt != base) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int r0;
    int d0;
    bit seen;

    chk_cnt    = 0;
    pass_cnt   = 0;
    rinc_cnt   = 0;
    done_cnt   = 0;
    prev_rinc  = 1'b0;
    rrst       = 1'b1;
    dout_ready = 1'b0;
    trail_arm  = 1'b0;
    stop_addr  = '0;
    wptr       = '0;
    raddr      = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

    fork
      // FIFO read-pointer model
      forever begin
        @(posedge rclk);
        if (rinc) raddr <= raddr + 9'd1;
      end
      // Output monitor / scoreboard
      forever begin
        @(negedge rclk);
        if (!rrst) begin
          if (rinc) rinc_cnt++;
          if (frame_done) done_cnt++;
          if (prev_rinc) check("rinc-to-valid latency", {31'd0, dout_valid}, 32'd1);
          if (dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
              chk_cnt++;
              $display("FAIL unexpected word: got %0h, expected none", dout_data);
            end else begin
              check("stream data", {24'd0, dout_data}, {24'd0, exp_q.pop_front()});
            end
          end
          prev_rinc = rinc;
        end else begin
          prev_rinc = 1'b0;
        end
      end
    join_none

    // Reset state
    repeat (2) tick();
    check("reset dout_valid", {31'd0, dout_valid}, 32'd0);
    check("reset dout_data", {24'd0, dout_data}, 32'd0);
    check("reset frame_done", {31'd0, frame_done}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset rinc", {31'd0, rinc}, 32'd0);
    rrst = 1'b0;
    tick();

    // Basic stream
    dout_ready = 1'b1;
    r0 = rinc_cnt;
    load(8'h11, 1'b1);
    load(8'h22, 1'b1);
    load(8'h33, 1'b1);
    repeat (6) tick();
    check("basic rinc count", rinc_cnt - r0, 32'd3);
    check("basic raddr", {23'd0, raddr}, 32'd3);
    check("basic busy", {31'd0, busy}, 32'd1);

    // Backpressure
    dout_ready = 1'b0;
    r0 = rinc_cnt;
    load(8'h44, 1'b1);
    load(8'h55, 1'b1);
    tick();
    repeat (4) tick();
    check("bp hold data", {24'd0, dout_data}, 32'h44);
    check("bp hold valid", {31'd0, dout_valid}, 32'd1);
    check("bp rinc count", rinc_cnt - r0, 32'd1);
    dout_ready = 1'b1;
    repeat (4) tick();
    check("bp resume rinc count", rinc_cnt - r0, 32'd2);
    check("bp raddr", {23'd0, raddr}, 32'd5);

    // Stop address: raddr=5, stop=8; 0x99 is read after the restart
    trail_arm = 1'b1;
    stop_addr = 9'd8;
    r0 = rinc_cnt;
    d0 = done_cnt;
    load(8'h66, 1'b1);
    load(8'h77, 1'b1);
    load(8'h88, 1'b1);
    load(8'h99, 1'b1);
    wait_done(20, seen);
    check("stop frame_done seen", {31'd0, seen}, 32'd1);
    check("stop rinc count", rinc_cnt - r0, 32'd3);
    check("stop raddr", {23'd0, raddr}, 32'd8);
    check("stop no rinc in DONE", {31'd0, rinc}, 32'd0);
`ifdef READ_UNIT_WORD_COUNT_EN
    check("word_count at frame_done", {22'd0, word_count}, 32'd8);
`endif
    tick();
    repeat (5) tick();
    check("stop single pulse", done_cnt - d0, 32'd1);
    check("restart reads past stop", {23'd0, raddr}, 32'd9);
`ifdef READ_UNIT_WORD_COUNT_EN
    check("word_count cleared on restart", {22'd0, word_count}, 32'd1);
`endif
    trail_arm = 1'b0;
    tick();

    // Immediate stop at 0x1FF, with the output register still occupied
    dout_ready = 1'b0;
    raddr <= 9'h1FE;
    wptr = 9'h1FE;
    load(8'h5A, 1'b1);
    load(8'h6B, 1'b1);
    tick();
    trail_arm = 1'b1;
    stop_addr = 9'h1FF;
    r0 = rinc_cnt;
    repeat (3) tick();
    check("imm no reads", rinc_cnt - r0, 32'd0);
    check("imm holds valid", {31'd0, dout_valid}, 32'd1);
    check("imm busy", {31'd0, busy}, 32'd1);
    dout_ready = 1'b1;
    wait_done(10, seen);
    check("imm frame_done seen", {31'd0, seen}, 32'd1);
    check("imm reads at done", rinc_cnt - r0, 32'd0);
    trail_arm = 1'b0;
    tick();
    repeat (5) tick();
    check("imm wrap raddr", {23'd0, raddr}, 32'd0);

    // Reset mid-stream
    dout_ready = 1'b0;
    load(8'h7C, 1'b0);
    repeat (3) tick();
    check("pre-reset valid", {31'd0, dout_valid}, 32'd1);
    rrst = 1'b1;
    #1;
    check("mid reset valid", {31'd0, dout_valid}, 32'd0);
    check("mid reset data", {24'd0, dout_data}, 32'd0);
    check("mid reset busy", {31'd0, busy}, 32'd0);
    load(8'h8D, 1'b1);
    #1;
    check("mid reset rinc", {31'd0, rinc}, 32'd0);
    tick();
    rrst = 1'b0;
    check("post reset rinc idle", {31'd0, rinc}, 32'd0);
    dout_ready = 1'b1;
    repeat (6) tick();
    check("post reset raddr", {23'd0, raddr}, 32'd2);
    check("scoreboard drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
